// File: rtl/fetch_pkg.sv
// Shared fetch constants and the default-width fetch queue entry.
package fetch_pkg;

  localparam int unsigned INSTR_BYTES = 4;
  localparam int unsigned FETCH_XLEN  = 32;

  typedef struct packed {
    logic [FETCH_XLEN-1:0] pc;
    logic [FETCH_XLEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/instr_fetch_queue_if.sv
// Fetch block bus: redirect input, instruction-memory port and decode handshake.
interface instr_fetch_queue_if #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned AW   = 10
);
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            imem_req;
  logic [AW-1:0]   imem_addr;
  logic [XLEN-1:0] imem_rdata;
  logic            if_valid;
  logic            if_ready;
  logic [XLEN-1:0] if_instr;
  logic [XLEN-1:0] if_pc;

  modport master (
    input  redirect_valid, redirect_pc, imem_rdata, if_ready,
    output imem_req, imem_addr, if_valid, if_instr, if_pc
  );

  modport slave (
    output redirect_valid, redirect_pc, imem_rdata, if_ready,
    input  imem_req, imem_addr, if_valid, if_instr, if_pc
  );
endinterface

// File: rtl/instr_fetch_queue_fifo.sv
// Circular FIFO of fetch entries with flush; flush takes priority over push/pop.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter type         T     = fetch_entry_t
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   push,
  input  T                       push_data,
  input  logic                   pop,
  output T                       head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);
  localparam int unsigned PW = $clog2(DEPTH);

  T             mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;
  logic          do_push, do_pop;

  // Next pointers/count; power-of-two depth lets pointers wrap naturally.
  always_comb begin
    full     = (count_q == (PW+1)'(DEPTH));
    empty    = (count_q == '0);
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    if (do_push && !do_pop) count_d = count_q + (PW+1)'(1);
    if (do_pop && !do_push) count_d = count_q - (PW+1)'(1);
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
    head  = mem_q[rd_ptr_q];
    count = count_q;
  end

  // Pointer and count registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents are only meaningful below count.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end
endmodule

// File: rtl/instr_fetch_queue.sv
// Instruction fetch: PC register, request throttling, redirect handling and a fetch queue.
module instr_fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     IM_DEPTH = 1024,
  parameter int unsigned     FQ_DEPTH = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input logic                 clk,
  input logic                 rst,
  instr_fetch_queue_if.master bus
);
  localparam int unsigned AW = $clog2(IM_DEPTH);
  localparam int unsigned CW = $clog2(FQ_DEPTH) + 1;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } entry_t;

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic            inflight_q, inflight_d;
  logic [XLEN-1:0] inflight_pc_q, inflight_pc_d;

  logic [XLEN-1:0] req_pc;
  logic [CW-1:0]   occupancy;
  logic            req;
  logic            fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [CW-1:0]   fifo_count;
  entry_t          push_entry, head_entry;
  logic            valid;

  // Request/redirect control and decode-side outputs.
  always_comb begin
    req_pc    = bus.redirect_valid ? (bus.redirect_pc & ~XLEN'(3)) : fetch_pc_q;
    occupancy = fifo_count + CW'(inflight_q);
    // A redirect flushes everything, so it always has room to issue.
    req       = !rst && (bus.redirect_valid || (occupancy < CW'(FQ_DEPTH)));

    fetch_pc_d    = req ? (req_pc + XLEN'(INSTR_BYTES)) : req_pc;
    inflight_d    = req;
    inflight_pc_d = req_pc;

    valid      = !fifo_empty && !rst && !bus.redirect_valid;
    fifo_pop   = valid && bus.if_ready;
    fifo_push  = inflight_q && !bus.redirect_valid && !rst && (!fifo_full || fifo_pop);
    push_entry = '{pc: inflight_pc_q, instr: bus.imem_rdata};

    bus.imem_req  = req;
    bus.imem_addr = req_pc[2 +: AW];
    bus.if_valid  = valid;
    bus.if_pc     = valid ? head_entry.pc    : '0;
    bus.if_instr  = valid ? head_entry.instr : '0;
  end

  // PC and in-flight tracking registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q    <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
    end
  end

  fetch_fifo #(
    .DEPTH (FQ_DEPTH),
    .T     (entry_t)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (bus.redirect_valid),
    .push      (fifo_push),
    .push_data (push_entry),
    .pop       (fifo_pop),
    .head      (head_entry),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );
endmodule

// File: tb/tb_instr_fetch_queue.sv
// Scoreboard bench for instr_fetch_queue: memory word[k] = 0x1000 + k.
module tb_instr_fetch_queue;
  logic clk;
  logic rst;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t exp_q[$];
  int   checks;
  int   errors;
  int   pops;

  instr_fetch_queue_if #(.XLEN(32), .AW(10)) bus ();

  instr_fetch_queue #(
    .XLEN     (32),
    .IM_DEPTH (1024),
    .FQ_DEPTH (4),
    .RESET_PC (32'h0)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory model: one-cycle read latency.
  always @(posedge clk) begin
    if (bus.imem_req) bus.imem_rdata <= 32'h1000 + {22'b0, bus.imem_addr};
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", name, got, want, $time);
    end
  endtask

  // Monitor: compare every accepted output against the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && bus.if_valid && bus.if_ready && !bus.redirect_valid) begin
      pops++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output got pc %h instr %h expected none", bus.if_pc, bus.if_instr);
      end else begin
        e = exp_q.pop_front();
        check("out_pc", bus.if_pc, e.pc);
        check("out_instr", bus.if_instr, e.instr);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic expect_out(input logic [31:0] pc, input logic [31:0] instr);
    exp_t e;
    e.pc    = pc;
    e.instr = instr;
    exp_q.push_back(e);
  endtask

  // Hold if_ready until n outputs have been accepted, bounded by budget cycles.
  task automatic run_ready(input int n, input int budget);
    int start;
    int k;
    start = pops;
    k = 0;
    bus.if_ready = 1'b1;
    while ((pops - start) < n && k < budget) begin
      tick();
      k++;
    end
    bus.if_ready = 1'b0;
    check("ready_window_pops", 32'(pops - start), 32'(n));
  endtask

  // Reset for two cycles; returns settled in the first cycle with rst low.
  task automatic do_reset();
    rst = 1'b1;
    bus.if_ready = 1'b0;
    bus.redirect_valid = 1'b0;
    tick();
    tick();
    check("rst_imem_req", bus.imem_req, 0);
    check("rst_if_valid", bus.if_valid, 0);
    check("rst_if_pc", bus.if_pc, 0);
    rst = 1'b0;
    settle();
  endtask

  initial begin
    int reqs;
    checks = 0;
    errors = 0;
    pops   = 0;
    rst = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.if_ready       = 1'b0;

    // Streaming from reset: two-cycle latency then one per cycle.
    do_reset();
    bus.if_ready = 1'b1;
    settle();
    check("c0_imem_req", bus.imem_req, 1);
    check("c0_imem_addr", 32'(bus.imem_addr), 0);
    check("c0_if_valid", bus.if_valid, 0);
    expect_out(32'h0, 32'h1000);
    expect_out(32'h4, 32'h1001);
    expect_out(32'h8, 32'h1002);
    tick();
    check("c1_if_valid", bus.if_valid, 0);
    check("c1_imem_addr", 32'(bus.imem_addr), 1);
    tick();
    check("c2_if_valid", bus.if_valid, 1);
    check("c2_if_pc", bus.if_pc, 0);
    run_ready(3, 20);

    // Mid-operation reset with three entries queued.
    tick();
    tick();
    check("prerst_if_valid", bus.if_valid, 1);
    check("prerst_if_pc", bus.if_pc, 32'hC);
    check("prerst_if_instr", bus.if_instr, 32'h1003);
    rst = 1'b1;
    settle();
    check("midrst_imem_req", bus.imem_req, 0);
    check("midrst_if_valid", bus.if_valid, 0);
    check("midrst_if_instr", bus.if_instr, 0);
    tick();
    rst = 1'b0;
    settle();
    check("postrst_c0_if_valid", bus.if_valid, 0);
    check("postrst_c0_imem_req", bus.imem_req, 1);
    check("postrst_c0_imem_addr", 32'(bus.imem_addr), 0);
    tick();
    check("postrst_c1_if_valid", bus.if_valid, 0);
    expect_out(32'h0, 32'h1000);
    expect_out(32'h4, 32'h1001);
    run_ready(2, 20);

    // Backpressure: exactly FQ_DEPTH requests, then resume on pop.
    do_reset();
    reqs = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus.imem_req) reqs++;
      tick();
    end
    check("bp_request_count", 32'(reqs), 4);
    check("bp_if_valid", bus.if_valid, 1);
    check("bp_if_pc", bus.if_pc, 0);
    expect_out(32'h0, 32'h1000);
    expect_out(32'h4, 32'h1001);
    expect_out(32'h8, 32'h1002);
    expect_out(32'hC, 32'h1003);
    run_ready(4, 20);
    tick();
    check("bp_next_pc", bus.if_pc, 32'h10);
    check("bp_next_instr", bus.if_instr, 32'h1004);

    // Redirect to 0x43 while the pc 8 response arrives.
    do_reset();
    bus.if_ready = 1'b1;
    expect_out(32'h0, 32'h1000);
    expect_out(32'h40, 32'h1010);
    expect_out(32'h44, 32'h1011);
    tick();
    tick();
    tick();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h43;
    settle();
    check("redir_imem_req", bus.imem_req, 1);
    check("redir_imem_addr", 32'(bus.imem_addr), 16);
    check("redir_if_valid", bus.if_valid, 0);
    check("redir_if_pc", bus.if_pc, 0);
    tick();
    bus.redirect_valid = 1'b0;
    settle();
    check("redir_next_addr", 32'(bus.imem_addr), 17);
    run_ready(2, 20);

    // Back-to-back redirects: only the second stream survives.
    do_reset();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h100;
    settle();
    check("b2b_first_addr", 32'(bus.imem_addr), 64);
    tick();
    bus.redirect_pc = 32'h200;
    settle();
    check("b2b_second_addr", 32'(bus.imem_addr), 128);
    tick();
    bus.redirect_valid = 1'b0;
    expect_out(32'h200, 32'h1080);
    expect_out(32'h204, 32'h1081);
    run_ready(2, 20);

    // Address wrap at the top of instruction memory.
    do_reset();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'hFFC;
    settle();
    check("wrap_addr_top", 32'(bus.imem_addr), 1023);
    tick();
    bus.redirect_valid = 1'b0;
    settle();
    check("wrap_addr_zero", 32'(bus.imem_addr), 0);
    expect_out(32'hFFC, 32'h13FF);
    expect_out(32'h1000, 32'h1000);
    expect_out(32'h1004, 32'h1001);
    run_ready(3, 20);

    tick();
    tick();
    check("scoreboard_drained", 32'(exp_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout got running expected finished");
    $fatal(1);
  end
endmodule

// File: doc/instr_fetch_queue.md
INSTR_FETCH_QUEUE -- requirements
Module: instr_fetch_queue

Interface
REQ-001 Parameter XLEN, default 32, instruction and PC width in bits.
REQ-002 Parameter IM_DEPTH, default 1024, instruction memory depth in words; power of two.
REQ-003 Parameter FQ_DEPTH, default 4, fetch queue entries; power of two, at least 2.
REQ-004 Parameter RESET_PC, default 0, byte address of the first fetch; word-aligned.
REQ-005 Port clk, input, 1, single clock; all state updates on its rising edge.
REQ-006 Port rst, input, 1, reset; synchronous and active-high.
REQ-007 Port redirect_valid, input, 1, branch/jump redirect request.
REQ-008 Port redirect_pc, input, XLEN, redirect target byte address.
REQ-009 Port imem_req, output, 1, read request to the instruction memory this cycle.
REQ-010 Port imem_addr, output, $clog2(IM_DEPTH), word index of the request.
REQ-011 Port imem_rdata, input, XLEN, read data; valid exactly one cycle after imem_req.
REQ-012 Port if_valid, output, 1, queue head holds a valid instruction.
REQ-013 Port if_ready, input, 1, decode accepts the head this cycle.
REQ-014 Port if_instr, output, XLEN, head instruction.
REQ-015 Port if_pc, output, XLEN, byte address of the head instruction.

Function
REQ-016 The block SHALL hold fetch_pc, the byte address of the next request; it advances by 4 bytes per issued request (XLEN/8 in general), never by XLEN.
REQ-017 The block SHALL form imem_addr from bits [2 +: $clog2(IM_DEPTH)] of the request address, so addresses wrap modulo IM_DEPTH words.
REQ-018 The block SHALL assert imem_req only when the queue count plus the in-flight response count is less than FQ_DEPTH, so the queue never overflows.
REQ-019 The block SHALL write each non-discarded response into the queue as the pair {request PC, imem_rdata} in the cycle the response arrives; if_valid rises the following cycle.
REQ-020 Latency: with the queue empty and no redirect, a request in cycle N SHALL produce if_valid in cycle N+2.
REQ-021 A pop SHALL occur when if_valid and if_ready are both high; output order is request order.
REQ-022 A push and a pop in the same cycle SHALL leave the count unchanged; queue pointers wrap modulo FQ_DEPTH.
REQ-023 While if_valid is low, if_instr and if_pc SHALL be driven to 0.
REQ-024 When redirect_valid is high, the block SHALL flush the queue, discard any in-flight or same-cycle response, and force if_valid low; a concurrent if_ready is ignored.
REQ-025 In a redirect cycle, the request address SHALL be redirect_pc with bits [1:0] cleared; fetch_pc then becomes that address + 4 if a request was issued, otherwise that address.
REQ-026 Back-to-back redirects SHALL each take effect; only the last redirect's stream reaches the queue.
REQ-027 With if_ready held low, the block SHALL stop requesting after FQ_DEPTH entries are held or in flight, then resume on the first pop.

Reset
REQ-028 On rst high at a clock edge: fetch_pc = RESET_PC, queue count = 0, pointers = 0, in-flight flag = 0.
REQ-029 During rst: imem_req = 0, if_valid = 0, if_instr = 0, if_pc = 0.
REQ-030 A reset mid-operation SHALL discard all queued and in-flight data; no response arriving in the cycle after reset is enqueued.
REQ-031 The first request SHALL issue in the first cycle with rst low.

Structure
REQ-032 Package fetch_pkg SHALL hold the INSTR_BYTES constant (4) and the fetch-entry struct type {pc, instr}.
REQ-033 The queue SHALL be a sub-module fetch_fifo, parameterised by depth and entry type, with push, pop, flush, count, full and empty.
REQ-034 Request/epoch control and the PC register SHALL live in instr_fetch_queue.

Verification
REQ-035 Reset release, memory word[k] = 0x1000+k, if_ready=1: if_valid in cycle 2, then one instruction per cycle: (pc 0, 0x1000), (4, 0x1001), (8, 0x1002).
REQ-036 if_ready=0 with FQ_DEPTH=4: exactly 4 requests issue, then none; raising if_ready delivers pcs 0,4,8,12 in order with no loss or duplication.
REQ-037 Redirect to 0x43 in the cycle a response for pc 8 arrives: the pc 8 entry is dropped, the next request address is word 16 (0x40), and the next output is pc 0x40.
REQ-038 Sequential fetch from pc 4*(IM_DEPTH-1): imem_addr goes IM_DEPTH-1 then 0; if_pc keeps incrementing to 4*IM_DEPTH.
REQ-039 rst asserted for 1 cycle while 3 entries are queued: if_valid is 0 the next cycle, and the first post-reset output is pc RESET_PC.
REQ-040 Redirects in two consecutive cycles, to 0x100 then 0x200: no entry with pc 0x100 is ever output; the first output is pc 0x200.
